bcd_to_binary: RTL and testbench

- Sequential BCD-to-binary decoder using iterative reverse double-dabble. It is the inverse of the existing binary-to-BCD converter.
- Takes packed BCD lag values (current/min/max, 5–6 digits) from the bcdcounter domain and returns a binary integer.
- Used for arithmetic on measured lag: averaging, threshold compare, export.
- Sits next to bcdcounter in the 27 MHz domain and shares its reset.

---
 rtl/bcd_to_binary.sv | 149 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per SHIFT/ADJUST pair.
// Optional digit checker enabled by defining BCD_TO_BINARY_CHECK_EN.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 6,
    parameter int OUTPUT_WIDTH   = 20
) (
    input  logic                          clock,
    input  logic                          reset_bcdcounter,
    input  logic                          start,
    input  logic [4*DECIMAL_DIGITS-1:0]   bcd_in,
    output logic                          busy,
    output logic [OUTPUT_WIDTH-1:0]       binary_out,
    output logic                          valid,
    output logic                          invalid
);

    localparam int BCD_W = 4 * DECIMAL_DIGITS;
    localparam int SR_W  = 2 * BCD_W;
    localparam int CNT_W = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ADJUST,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [OUTPUT_WIDTH-1:0] bin_q, bin_d;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    accept;
    logic                    complete;

    // A digit whose MSB was filled by the neighbour's shifted-out bit counts 8 but means 5.
    function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] digits);
        logic [BCD_W-1:0] r;
        r = digits;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (digits[4*i+3]) r[4*i +: 4] = digits[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    assign accept   = (state_q == S_IDLE) && start;
    assign complete = (state_q == S_ADJUST) && (cnt_q == LAST_CNT);

    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bin_q   <= bin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SHIFT;
            S_SHIFT:  state_d = S_ADJUST;
            S_ADJUST: state_d = (cnt_q == LAST_CNT) ? S_DONE : S_SHIFT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bin_d   = bin_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d   = {bcd_in, {BCD_W{1'b0}}};
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_SHIFT: begin
                sr_d  = sr_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_ADJUST: begin
                sr_d = {adjust_digits(sr_q[SR_W-1:BCD_W]), sr_q[BCD_W-1:0]};
                if (complete) begin
                    bin_d   = result;
                    valid_d = 1'b1;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef BCD_TO_BINARY_CHECK_EN
    logic bad_q, bad_d;
    logic inv_q, inv_d;

    always_comb begin
        bad_d = bad_q;
        if (accept) begin
            bad_d = 1'b0;
            for (int i = 0; i < DECIMAL_DIGITS; i++) begin
                if (bcd_in[4*i +: 4] > 4'd9) bad_d = 1'b1;
            end
        end
        inv_d = complete ? bad_q : inv_q;
    end

    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            bad_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            inv_q <= inv_d;
        end
    end

    assign result  = bad_q ? '0 : OUTPUT_WIDTH'(sr_q[BCD_W-1:0]);
    assign invalid = inv_q;
`else
    assign result  = OUTPUT_WIDTH'(sr_q[BCD_W-1:0]);
    assign invalid = 1'b0;
`endif

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign binary_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: default 20-bit instance plus a 16-bit instance sharing stimulus.
// Reference values come from plain decimal arithmetic on the BCD digits.
module tb_bcd_to_binary;

    logic        clock = 1'b0;
    logic        reset_bcdcounter;
    logic        start;
    logic [23:0] bcd_in;
    logic        busy, valid, invalid;
    logic [19:0] binary_out;
    logic        busy16, valid16, invalid16;
    logic [15:0] binary_out16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bcd_to_binary #(.DECIMAL_DIGITS(6), .OUTPUT_WIDTH(20)) dut (
        .clock(clock), .reset_bcdcounter(reset_bcdcounter), .start(start), .bcd_in(bcd_in),
        .busy(busy), .binary_out(binary_out), .valid(valid), .invalid(invalid)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(6), .OUTPUT_WIDTH(16)) dut16 (
        .clock(clock), .reset_bcdcounter(reset_bcdcounter), .start(start), .bcd_in(bcd_in),
        .busy(busy16), .binary_out(binary_out16), .valid(valid16), .invalid(invalid16)
    );

    function automatic longint bcd_value(input logic [23:0] b);
        longint v = 0;
        for (int i = 5; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic has_bad_digit(input logic [23:0] b);
        logic bad = 1'b0;
        for (int i = 0; i < 6; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [23:0] rand_bcd(input int max_digit);
        logic [23:0] b;
        for (int i = 0; i < 6; i++) b[4*i +: 4] = 4'($urandom_range(0, max_digit));
        return b;
    endfunction

    function automatic logic [19:0] exp20(input logic [23:0] b);
`ifdef BCD_TO_BINARY_CHECK_EN
        if (has_bad_digit(b)) return 20'd0;
`endif
        return 20'(bcd_value(b) % 64'd1048576);
    endfunction

    function automatic logic [15:0] exp16(input logic [23:0] b);
`ifdef BCD_TO_BINARY_CHECK_EN
        if (has_bad_digit(b)) return 16'd0;
`endif
        return 16'(bcd_value(b) % 64'd65536);
    endfunction

    function automatic logic exp_inv(input logic [23:0] b);
`ifdef BCD_TO_BINARY_CHECK_EN
        return has_bad_digit(b);
`else
        return 1'b0 & b[0];
`endif
    endfunction

    // One conversion; lat = rising edges from the accepting edge to the edge that raised valid.
    task automatic convert(input logic [23:0] b, output logic [19:0] r20, output logic [15:0] r16,
                           output logic inv, output int lat, output logic busy0,
                           output logic v16, output int extra_valid, output logic busy_after);
        @(negedge clock);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clock);
        start  = 1'b0;
        busy0  = busy;
        lat    = 0;
        while (!valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        r20 = binary_out;
        r16 = binary_out16;
        inv = invalid;
        v16 = valid16;
        extra_valid = 0;
        @(negedge clock);
        busy_after = busy;
        for (int i = 0; i < 3; i++) begin
            if (valid) extra_valid++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset_bcdcounter = 1'b1;
        start  = 1'b0;
        bcd_in = 24'h0;
        #12;
        n_cmp++;
        if ({busy, valid, invalid, binary_out} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_in: busy=%b valid=%b invalid=%b out=%0d, want all 0", busy, valid, invalid, binary_out);
        end
        n_cmp++;
        if ({busy16, valid16, invalid16, binary_out16} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_in16: busy=%b valid=%b invalid=%b out=%0d, want all 0", busy16, valid16, invalid16, binary_out16);
        end
        @(negedge clock);
        reset_bcdcounter = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy, valid, binary_out} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b valid=%b out=%0d, want all 0", busy, valid, binary_out);
        end
    endtask

    task automatic test_known;
        logic [23:0] vec [4] = '{24'h999999, 24'h000000, 24'h000001, 24'h012345};
        logic [19:0] want [4] = '{20'd999999, 20'd0, 20'd1, 20'd12345};
        logic [19:0] r20; logic [15:0] r16; logic inv, b0, v16, ba; int lat, ev;
        for (int i = 0; i < 4; i++) begin
            convert(vec[i], r20, r16, inv, lat, b0, v16, ev, ba);
            n_cmp++;
            if (r20 !== want[i]) begin n_bad++; $display("FAIL known_value %h: got %0d want %0d", vec[i], r20, want[i]); end
            n_cmp++;
            if (lat !== 48) begin n_bad++; $display("FAIL known_latency %h: got %0d want 48", vec[i], lat); end
            n_cmp++;
            if (b0 !== 1'b1) begin n_bad++; $display("FAIL known_busy_start %h: got %b want 1", vec[i], b0); end
            n_cmp++;
            if (ev !== 0 || ba !== 1'b0) begin
                n_bad++; $display("FAIL known_pulse %h: extra valid %0d busy_after %b, want 0/0", vec[i], ev, ba);
            end
            n_cmp++;
            if (r16 !== 16'(want[i]) || v16 !== 1'b1) begin
                n_bad++; $display("FAIL known_w16 %h: got %0d v=%b want %0d v=1", vec[i], r16, v16, 16'(want[i]));
            end
            n_cmp++;
            if (inv !== 1'b0) begin n_bad++; $display("FAIL known_invalid %h: got %b want 0", vec[i], inv); end
        end
    endtask

    task automatic test_width16;
        logic [19:0] r20; logic [15:0] r16; logic inv, b0, v16, ba; int lat, ev;
        convert(24'h099999, r20, r16, inv, lat, b0, v16, ev, ba);
        n_cmp++;
        if (r16 !== 16'h869F) begin n_bad++; $display("FAIL width16_trunc: got %h want 869f", r16); end
        n_cmp++;
        if (r20 !== 20'd99999) begin n_bad++; $display("FAIL width20_99999: got %0d want 99999", r20); end
    endtask

    task automatic test_random;
        logic [23:0] b; logic [19:0] r20; logic [15:0] r16; logic inv, b0, v16, ba; int lat, ev;
        for (int n = 0; n < 16; n++) begin
`ifdef BCD_TO_BINARY_CHECK_EN
            b = rand_bcd((n % 2 == 1) ? 15 : 9);
`else
            b = rand_bcd(9);
`endif
            convert(b, r20, r16, inv, lat, b0, v16, ev, ba);
            n_cmp++;
            if (r20 !== exp20(b) || r16 !== exp16(b) || inv !== exp_inv(b) || lat !== 48) begin
                n_bad++;
                $display("FAIL random %h: out=%0d/%0d inv=%b lat=%0d want %0d/%0d inv=%b lat=48",
                         b, r20, r16, inv, lat, exp20(b), exp16(b), exp_inv(b));
            end
        end
    endtask

    task automatic test_ignored_start;
        int k; int seen;
        @(negedge clock);
        start = 1'b1; bcd_in = 24'h000500;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        start = 1'b1; bcd_in = 24'h999999;
        @(negedge clock);
        start = 1'b0; bcd_in = 24'h777777;
        k = 11;
        while (!valid && k < 200) begin @(negedge clock); k++; end
        n_cmp++;
        if (k !== 48 || binary_out !== 20'd500) begin
            n_bad++; $display("FAIL ignored_start: lat=%0d out=%0d want 48/500", k, binary_out);
        end
        // a request sampled in DONE must be dropped as well
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (valid || busy) seen++;
            @(negedge clock);
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL ignored_no_second: %0d active cycles want 0", seen); end
    endtask

    task automatic test_mid_reset;
        logic [19:0] r20; logic [15:0] r16; logic inv, b0, v16, ba; int lat, ev, seen;
        convert(24'h000777, r20, r16, inv, lat, b0, v16, ev, ba);
        n_cmp++;
        if (r20 !== 20'd777) begin n_bad++; $display("FAIL pre_reset_value: got %0d want 777", r20); end
        @(negedge clock);
        start = 1'b1; bcd_in = 24'h123456;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        #2 reset_bcdcounter = 1'b1;
        #1;
        n_cmp++;
        if ({busy, valid, invalid, binary_out} !== 23'd0) begin
            n_bad++; $display("FAIL mid_reset_async: busy=%b valid=%b inv=%b out=%0d want all 0", busy, valid, invalid, binary_out);
        end
        @(negedge clock);
        reset_bcdcounter = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (valid || busy) seen++;
            @(negedge clock);
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_abandon: %0d active cycles want 0", seen); end
        convert(24'h000042, r20, r16, inv, lat, b0, v16, ev, ba);
        n_cmp++;
        if (r20 !== 20'd42 || lat !== 48) begin n_bad++; $display("FAIL after_reset_42: got %0d lat %0d want 42/48", r20, lat); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] a, b;
        int c; int nv; int at [3]; logic [19:0] got [3];
        a = rand_bcd(9); b = rand_bcd(9);
        @(negedge clock);
        start = 1'b1; bcd_in = a;
        c = 0; nv = 0;
        while (nv < 3 && c < 400) begin
            @(negedge clock);
            c++;
            if (valid) begin
                at[nv] = c; got[nv] = binary_out; nv++;
                bcd_in = b;
                if (nv == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (nv !== 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d pulses want 3", nv);
        end else begin
            n_cmp++;
            if (at[1] - at[0] !== 50 || at[2] - at[1] !== 50) begin
                n_bad++; $display("FAIL b2b_period: got %0d,%0d want 50,50", at[1] - at[0], at[2] - at[1]);
            end
            n_cmp++;
            if (got[0] !== exp20(a) || got[1] !== exp20(b) || got[2] !== exp20(b)) begin
                n_bad++; $display("FAIL b2b_values: got %0d,%0d,%0d want %0d,%0d,%0d",
                                  got[0], got[1], got[2], exp20(a), exp20(b), exp20(b));
            end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_check;
        logic [19:0] r20, r20b; logic [15:0] r16; logic inv, b0, v16, ba; int lat, ev;
        convert(24'h00000A, r20, r16, inv, lat, b0, v16, ev, ba);
`ifdef BCD_TO_BINARY_CHECK_EN
        n_cmp++;
        if (inv !== 1'b1 || r20 !== 20'd0) begin n_bad++; $display("FAIL check_bad_digit: inv=%b out=%0d want 1/0", inv, r20); end
        repeat (5) @(negedge clock);
        n_cmp++;
        if (invalid !== 1'b1) begin n_bad++; $display("FAIL check_hold: inv=%b want 1", invalid); end
        convert(24'h000010, r20, r16, inv, lat, b0, v16, ev, ba);
        n_cmp++;
        if (inv !== 1'b0 || r20 !== 20'd10) begin n_bad++; $display("FAIL check_clear: inv=%b out=%0d want 0/10", inv, r20); end
`else
        convert(24'h00000A, r20b, r16, inv, lat, b0, v16, ev, ba);
        n_cmp++;
        if (r20b !== r20 || inv !== 1'b0 || lat !== 48) begin
            n_bad++; $display("FAIL unchecked_repeat: out=%0d then %0d inv=%b lat=%0d want equal/0/48", r20, r20b, inv, lat);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_known();
        test_width16();
        test_random();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
